// File: rtl/ysyx_24110015_axi_arbiter.sv
// rtl/ysyx_24110015_axi_arbiter.sv - two-master round-robin AXI-lite arbiter onto one slave port
module ysyx_24110015_axi_arbiter #(
  parameter bit RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m0_awaddr,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,

  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,

  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,

  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0   = 3'd1,
    W0   = 3'd2,
    R1   = 3'd3,
    W1   = 3'd4
  } state_t;

  state_t state;
  logic   last;

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;

  // A master requests when it has either an address read or address write pending.
  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

  // On contention the master that was not granted last wins.
  assign grant0 = req0 & (~req1 | last);
  assign grant1 = req1 & (~req0 | ~last);

  // Arbitration FSM: grant from IDLE, hold the slave until R or B handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= RR_INIT;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            state <= m0_arvalid ? R0 : W0;
            last  <= 1'b0;
            busy  <= 1'b1;
          end else if (grant1) begin
            state <= m1_arvalid ? R1 : W1;
            last  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        R0: begin
          if (s_rvalid && m0_rready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        W0: begin
          if (s_bvalid && m0_bready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        R1: begin
          if (s_rvalid && m1_rready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        W1: begin
          if (s_bvalid && m1_bready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Channel routing: only the granted master's active channels are wired through, all else held at 0.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = 32'd0;
    m0_rresp   = 2'd0;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bresp   = 2'd0;
    m0_bvalid  = 1'b0;

    m1_arready = 1'b0;
    m1_rdata   = 32'd0;
    m1_rresp   = 2'd0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = 2'd0;
    m1_bvalid  = 1'b0;

    s_araddr   = 32'd0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = 32'd0;
    s_awvalid  = 1'b0;
    s_wdata    = 32'd0;
    s_wstrb    = 4'd0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    case (state)
      R0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      R1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      W0: begin
        s_awaddr   = m0_awaddr;
        s_awvalid  = m0_awvalid;
        m0_awready = s_awready;
        s_wdata    = m0_wdata;
        s_wstrb    = m0_wstrb;
        s_wvalid   = m0_wvalid;
        m0_wready  = s_wready;
        m0_bresp   = s_bresp;
        m0_bvalid  = s_bvalid;
        s_bready   = m0_bready;
      end
      W1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// tb/tb_ysyx_24110015_axi_arbiter.sv - scoreboard bench for the two-master AXI-lite arbiter
module tb_ysyx_24110015_axi_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
  logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
  logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;
  logic        busy;

  ysyx_24110015_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } txn_t;

  typedef struct {
    int          who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic        gv;
    int          leak;
    int          waits;
  } obs_t;

  txn_t        sb[$];
  logic [33:0] rmap [logic [31:0]];
  logic [1:0]  bmap [logic [31:0]];
  int          n_cmp;
  int          n_bad;
  bit          last_model;

  function automatic bit other_active(input int oth);
    if (oth == 0)
      return m0_arready | m0_rvalid | m0_awready | m0_wready | m0_bvalid | (|m0_rdata) | (|m0_bresp);
    return m1_arready | m1_rvalid | m1_awready | m1_wready | m1_bvalid | (|m1_rdata) | (|m1_bresp);
  endfunction

  function automatic txn_t pop_exp();
    txn_t t;
    if (sb.size() == 0) begin
      t.who = -2; t.wr = 1'b0; t.addr = '0; t.data = '0; t.strb = '0; t.resp = '0;
      return t;
    end
    return sb.pop_front();
  endfunction

  task automatic m_read(input int w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    txn_t t;
    t.who = w; t.wr = 1'b0; t.addr = a; t.data = d; t.strb = 4'd0; t.resp = r;
    sb.push_back(t);
    rmap[a] = {r, d};
    if (w == 0) begin m0_araddr = a; m0_arvalid = 1'b1; end
    else begin m1_araddr = a; m1_arvalid = 1'b1; end
  endtask

  task automatic m_write(input int w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] r);
    txn_t t;
    t.who = w; t.wr = 1'b1; t.addr = a; t.data = d; t.strb = s; t.resp = r;
    sb.push_back(t);
    bmap[a] = r;
    if (w == 0) begin
      m0_awaddr = a; m0_awvalid = 1'b1; m0_wdata = d; m0_wstrb = s; m0_wvalid = 1'b1;
    end else begin
      m1_awaddr = a; m1_awvalid = 1'b1; m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1;
    end
  endtask

  // Slave + master handshake driver for one forwarded transaction; returns what was observed.
  task automatic serve(input int rdelay, output obs_t o);
    int oth;
    o.who = -1; o.wr = 1'b0; o.addr = '0; o.data = '0; o.strb = '0; o.resp = '0;
    o.gv = 1'b0; o.leak = 0; o.waits = 0;
    while (1) begin
      @(negedge clk); #1;
      o.waits++;
      if (s_arvalid || s_awvalid || o.waits >= 40) break;
    end
    if (s_arvalid) begin
      o.addr = s_araddr;
      s_arready = 1'b1; #1;
      if (m0_arready && !m1_arready) o.who = 0;
      else if (m1_arready && !m0_arready) o.who = 1;
      oth = (o.who == 0) ? 1 : 0;
      @(negedge clk);
      s_arready = 1'b0;
      if (o.who == 0) m0_arvalid = 1'b0; else if (o.who == 1) m1_arvalid = 1'b0;
      for (int i = 0; i < rdelay; i++) begin
        #1;
        if (other_active(oth)) o.leak++;
        @(negedge clk);
      end
      if (rmap.exists(o.addr)) {s_rresp, s_rdata} = rmap[o.addr];
      else {s_rresp, s_rdata} = '0;
      s_rvalid = 1'b1; #1;
      o.gv   = (o.who == 1) ? m1_rvalid : m0_rvalid;
      o.data = (o.who == 1) ? m1_rdata  : m0_rdata;
      o.resp = (o.who == 1) ? m1_rresp  : m0_rresp;
      if (other_active(oth)) o.leak++;
      @(negedge clk);
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    end else if (s_awvalid) begin
      o.wr = 1'b1; o.addr = s_awaddr; o.data = s_wdata; o.strb = s_wstrb;
      s_awready = 1'b1; s_wready = 1'b1; #1;
      if (m0_awready && m0_wready && !m1_awready) o.who = 0;
      else if (m1_awready && m1_wready && !m0_awready) o.who = 1;
      oth = (o.who == 0) ? 1 : 0;
      @(negedge clk);
      s_awready = 1'b0; s_wready = 1'b0;
      if (o.who == 0) begin m0_awvalid = 1'b0; m0_wvalid = 1'b0; end
      else if (o.who == 1) begin m1_awvalid = 1'b0; m1_wvalid = 1'b0; end
      s_bresp = bmap.exists(o.addr) ? bmap[o.addr] : 2'd0;
      s_bvalid = 1'b1; #1;
      o.gv   = (o.who == 1) ? m1_bvalid : m0_bvalid;
      o.resp = (o.who == 1) ? m1_bresp  : m0_bresp;
      if (other_active(oth)) o.leak++;
      @(negedge clk);
      s_bvalid = 1'b0; s_bresp = '0;
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    m0_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    v = {busy, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
         m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid,
         m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
    n_cmp++;
    if (v !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0000", v);
    end
    m0_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read;
    obs_t o; txn_t e;
    @(negedge clk);
    m_read(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00);
    #1;
    n_cmp++;
    if (s_arvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL read_no_idle_forward: s_arvalid=%b busy=%b want 0 0", s_arvalid, busy);
    end
    serve(3, o); #1; e = pop_exp();
    n_cmp++;
    if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
        o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL read_m0: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
               o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
    end
  endtask

  task automatic test_contest;
    obs_t o; txn_t e;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_read(0, 32'h8000_0100, 32'h0102_0304, 2'b00);
    m_write(1, 32'h8000_0104, 32'hA0B0_C0D0, 4'hF, 2'b00);
    repeat (2) begin
      serve(2, o); #1; e = pop_exp();
      n_cmp++;
      if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
          o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL contest_first: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
                 o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
      end
    end
    @(negedge clk);
    m_write(0, 32'h8000_0200, 32'h7777_8888, 4'h5, 2'b01);
    m_read(1, 32'h8000_0204, 32'h9999_AAAA, 2'b11);
    repeat (2) begin
      serve(1, o); #1; e = pop_exp();
      n_cmp++;
      if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
          o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL contest_second: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
                 o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
      end
    end
  endtask

  task automatic test_write;
    obs_t o; txn_t e;
    @(negedge clk);
    m_write(1, 32'h8000_1000, 32'h1234_5678, 4'h3, 2'b10);
    #1;
    n_cmp++;
    if (s_wvalid !== 1'b0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
      n_bad++;
      $display("FAIL write_idle_data: s_wvalid=%b s_wdata=%h s_wstrb=%h want 0 0 0", s_wvalid, s_wdata, s_wstrb);
    end
    serve(0, o); #1; e = pop_exp();
    n_cmp++;
    if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
        o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL write_m1: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
               o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
    end
  endtask

  task automatic test_same_master;
    obs_t o; txn_t e;
    @(negedge clk);
    m_read(1, 32'h8000_4000, 32'hCAFE_F00D, 2'b00);
    m_write(1, 32'h8000_4004, 32'h0BAD_F00D, 4'hF, 2'b01);
    repeat (2) begin
      serve(2, o); #1; e = pop_exp();
      n_cmp++;
      if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
          o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL same_master: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
                 o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; txn_t e;
    @(negedge clk);
    m0_araddr = 32'h8000_2000; m0_arvalid = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (s_arvalid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_granted: s_arvalid=%b busy=%b want 1 1", s_arvalid, busy);
    end
    rst = 1'b1; #1;
    n_cmp++;
    if ({busy, s_arvalid, s_rready, m0_arready, m0_rvalid, m1_arready, m1_rvalid} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid_cleared: got %b want 0000000",
               {busy, s_arvalid, s_rready, m0_arready, m0_rvalid, m1_arready, m1_rvalid});
    end
    m0_arvalid = 1'b0;
    m_read(1, 32'h8000_3000, 32'h3333_3333, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    serve(2, o); #1; e = pop_exp();
    n_cmp++;
    if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
        o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
               o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
    end
  endtask

  task automatic test_stall;
    obs_t o; txn_t e;
    @(negedge clk);
    m_read(0, 32'h8000_5000, 32'h5A5A_5A5A, 2'b00);
    m_read(1, 32'h8000_5004, 32'hA5A5_A5A5, 2'b00);
    for (int k = 0; k < 2; k++) begin
      serve((k == 0) ? 200 : 1, o); #1; e = pop_exp();
      n_cmp++;
      if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
          o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_%0d: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
                 k, o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
      end
    end
  endtask

  task automatic issue(input int w, input int rnd);
    logic [31:0] a;
    a = 32'h9000_0000 + 32'(rnd * 16 + w * 8);
    if ($urandom_range(0, 1) == 1)
      m_read(w, a, $urandom, 2'($urandom_range(0, 3)));
    else
      m_write(w, a, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_back_to_back;
    obs_t o; txn_t e;
    int   mask;
    int   first;
    // m1 was the last master granted in the stall scenario
    last_model = 1'b1;
    for (int rnd = 0; rnd < 6; rnd++) begin
      @(negedge clk);
      mask = $urandom_range(1, 3);
      if (mask == 3) first = last_model ? 0 : 1;
      else first = (mask == 2) ? 1 : 0;
      issue(first, rnd);
      if (mask == 3) issue(1 - first, rnd);
      last_model = (mask == 3) ? bit'(1 - first) : bit'(first);
      repeat ((mask == 3) ? 2 : 1) begin
        serve($urandom_range(0, 4), o); #1; e = pop_exp();
        n_cmp++;
        if (o.who !== e.who || o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb ||
            o.resp !== e.resp || o.gv !== 1'b1 || o.leak != 0 || o.waits != 1 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_%0d: got who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=%b leak=%0d wait=%0d busy=%b; want who=%0d wr=%b addr=%h data=%h strb=%h resp=%0d v=1 leak=0 wait=1 busy=0",
                   rnd, o.who, o.wr, o.addr, o.data, o.strb, o.resp, o.gv, o.leak, o.waits, busy, e.who, e.wr, e.addr, e.data, e.strb, e.resp);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; last_model = 1'b1;
    rst = 1'b1;
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1; m0_awaddr = '0; m0_awvalid = 1'b0;
    m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 1'b0; m0_bready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1; m1_awaddr = '0; m1_awvalid = 1'b0;
    m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0; m1_bready = 1'b1;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;

    test_reset();
    test_read();
    test_contest();
    test_write();
    test_same_master();
    test_reset_mid();
    test_stall();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
